stream_bram_bridge: RTL and testbench

Parametrised successor to the DMA-to-BRAM stream bridge. Moves `len` words between an AXI4-Stream pair (DMA MM2S / S2MM) and an internal true-dual-port block RAM. Adds full ready/valid backpressure on both stream directions, a configurable address stride, TLAST-based early termination with error reporting, and status outputs. Port B of the RAM stays dedicated to the compute datapath.

---
 rtl/stream_bram_bridge_if.sv | 50 +++++
 rtl/stream_bram_bridge.sv | 131 +++++++++++++
 tb/tb_stream_bram_bridge.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stream_bram_bridge_if.sv
// stream_bram_bridge_if: command/status, AXI4-Stream in/out and compute-port
// signals of the stream/BRAM bridge, with master (driver) and slave (bridge) views.
interface stream_bram_bridge_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
);
   logic                  start;
   logic                  dir;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] stride;
   logic [LEN_WIDTH-1:0]  len;
   logic                  busy;
   logic                  done;
   logic                  err_last;
   logic [LEN_WIDTH-1:0]  xfer_count;
   logic                  s_axis_valid;
   logic [DATA_WIDTH-1:0] s_axis_data;
   logic                  s_axis_last;
   logic                  s_axis_ready;
   logic                  m_axis_valid;
   logic [DATA_WIDTH-1:0] m_axis_data;
   logic                  m_axis_last;
   logic                  m_axis_ready;
   logic                  comp_en_b;
   logic                  comp_we_b;
   logic [ADDR_WIDTH-1:0] comp_addr_b;
   logic [DATA_WIDTH-1:0] comp_din_b;
   logic [DATA_WIDTH-1:0] comp_dout_b;
   modport slave (
      input  start, dir, base_addr, stride, len,
      output busy, done, err_last, xfer_count,
      input  s_axis_valid, s_axis_data, s_axis_last,
      output s_axis_ready,
      output m_axis_valid, m_axis_data, m_axis_last,
      input  m_axis_ready,
      input  comp_en_b, comp_we_b, comp_addr_b, comp_din_b,
      output comp_dout_b
   );
   modport master (
      output start, dir, base_addr, stride, len,
      input  busy, done, err_last, xfer_count,
      output s_axis_valid, s_axis_data, s_axis_last,
      input  s_axis_ready,
      input  m_axis_valid, m_axis_data, m_axis_last,
      output m_axis_ready,
      output comp_en_b, comp_we_b, comp_addr_b, comp_din_b,
      input  comp_dout_b
   );
endinterface

// File: rtl/stream_bram_bridge.sv
// stream_bram_bridge: moves len words between AXI4-Stream and a true-dual-port BRAM
// using strided addressing and TLAST checking; port B serves the compute datapath.
module stream_bram_bridge #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   stream_bram_bridge_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, iss_q, iss_d, cnt_inc;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, pend_q, pend_d;
   logic [DATA_WIDTH-1:0] fifo_q [3];
   logic [DATA_WIDTH-1:0] fifo_d [3];
   logic [1:0]            rp_q, rp_d, wp_q, wp_d, occ_q, occ_d;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] dout_a, dout_b;
   logic                  s_hs, issue, pop, beat_last;
   assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
   assign beat_last = cnt_inc == len_q;
   assign s_hs      = state_q == WRITE && bus.s_axis_valid;
   // a read is allowed only if the FIFO can still absorb it when it returns
   assign issue = state_q == READ && iss_q != len_q && ({1'b0, occ_q} + {2'b0, pend_q}) < 3'd3;
   assign pop   = state_q == READ && occ_q != 2'd0 && bus.m_axis_ready;
   assign bus.s_axis_ready = state_q == WRITE;
   assign bus.m_axis_valid = occ_q != 2'd0;
   assign bus.m_axis_data  = fifo_q[rp_q];
   assign bus.m_axis_last  = occ_q != 2'd0 && beat_last;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err_last     = err_q;
   assign bus.xfer_count   = cnt_q;
   assign bus.comp_dout_b  = dout_b;
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      iss_d    = iss_q;
      err_d    = err_q;
      done_d   = 1'b0;
      fifo_d   = fifo_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d  = bus.len == '0 ? DONE : bus.dir ? READ : WRITE;
            addr_d   = bus.base_addr;
            stride_d = bus.stride;
            len_d    = bus.len;
            cnt_d    = '0;
            iss_d    = '0;
            err_d    = 1'b0;
         end
         WRITE: if (s_hs) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_inc;
            if (beat_last || bus.s_axis_last) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = beat_last != bus.s_axis_last;
            end
         end
         READ: begin
            addr_d = issue ? addr_q + stride_q : addr_q;
            iss_d  = issue ? iss_q + LEN_WIDTH'(1) : iss_q;
            if (pop) begin
               cnt_d = cnt_inc;
               if (beat_last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            // a zero-length command enters DONE without the pulse, so it spends one extra cycle here
            state_d = done_q ? IDLE : DONE;
            done_d  = !done_q;
         end
      endcase
      if (pend_q) fifo_d[wp_q] = dout_a;
      wp_d   = pend_q ? (wp_q == 2'd2 ? 2'd0 : wp_q + 2'd1) : wp_q;
      rp_d   = pop ? (rp_q == 2'd2 ? 2'd0 : rp_q + 2'd1) : rp_q;
      occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
      pend_d = issue;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         iss_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         fifo_q   <= '{default: '0};
         rp_q     <= '0;
         wp_q     <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         iss_q    <= iss_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
         fifo_q   <= fifo_d;
         rp_q     <= rp_d;
         wp_q     <= wp_d;
         occ_q    <= occ_d;
      end
   end
   // read-first on both ports; port B is written last so it wins a write/write collision
   always_ff @(posedge clk) begin
      if (s_hs) mem[addr_q] <= bus.s_axis_data;
      if (bus.comp_en_b && bus.comp_we_b) mem[bus.comp_addr_b] <= bus.comp_din_b;
      if (issue) dout_a <= mem[addr_q];
      if (bus.comp_en_b) dout_b <= mem[bus.comp_addr_b];
   end
endmodule

// File: tb/tb_stream_bram_bridge.sv
// tb_stream_bram_bridge: directed transfers on both stream directions plus a
// table of port-B readbacks checked against a bench-side memory model.
module tb_stream_bram_bridge;
   localparam int AW = 13;
   localparam int DW = 32;
   localparam int LW = 16;
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] model [int];
   vec_t tbl [15];
   always #5 clk = ~clk;
   stream_bram_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
   stream_bram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_cmd(input logic d, input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input logic [LW-1:0] l);
      bus.start = 1'b1;
      bus.dir = d;
      bus.base_addr = b;
      bus.stride = s;
      bus.len = l;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic write_xfer(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [LW-1:0] len, input int nb, input int last_at,
                             input logic [DW-1:0] d0, input logic exp_err);
      logic [AW-1:0] a;
      start_cmd(1'b0, base, stride, len);
      chk("wr_err_clear", bus.err_last, 0);
      for (int i = 0; i < nb; i++) begin
         chk("wr_ready", bus.s_axis_ready, 1);
         a = base + AW'(i) * stride;
         bus.s_axis_valid = 1'b1;
         bus.s_axis_data = d0 + DW'(i);
         bus.s_axis_last = (i + 1 == last_at);
         model[int'(a)] = d0 + DW'(i);
         @(negedge clk);
      end
      bus.s_axis_valid = 1'b0;
      bus.s_axis_last = 1'b0;
      chk("wr_done", bus.done, 1);
      chk("wr_err", bus.err_last, exp_err);
      chk("wr_count", bus.xfer_count, nb);
      chk("wr_ready_off", bus.s_axis_ready, 0);
      @(negedge clk);
      chk("wr_done_pulse", bus.done, 0);
   endtask

   task automatic read_xfer(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input logic [LW-1:0] len, input logic [3:0] pat);
      int k = 0;
      int c = 0;
      int first = -1;
      int lastc = -1;
      logic [AW-1:0] a;
      start_cmd(1'b1, base, stride, len);
      chk("rd_err_clear", bus.err_last, 0);
      while (k < int'(len) && c < 200) begin
         if (bus.m_axis_valid) begin
            if (first < 0) first = c;
            a = base + AW'(k) * stride;
            if (model.exists(int'(a))) chk("rd_data", bus.m_axis_data, model[int'(a)]);
            chk("rd_last", bus.m_axis_last, k == int'(len) - 1);
         end
         bus.m_axis_ready = pat[3 - (c % 4)];
         if (bus.m_axis_valid && bus.m_axis_ready) begin
            k++;
            lastc = c;
         end
         @(negedge clk);
         c++;
      end
      bus.m_axis_ready = 1'b0;
      if (k < int'(len)) begin
         checks++;
         errors++;
         $display("FAIL rd_timeout: got %0d beats expected %0d", k, len);
      end
      chk("rd_first_valid", first, 2);
      if (pat == 4'b1111) chk("rd_throughput", lastc - first, int'(len) - 1);
      chk("rd_done", bus.done, 1);
      chk("rd_count", bus.xfer_count, len);
      chk("rd_valid_off", bus.m_axis_valid, 0);
      @(negedge clk);
   endtask

   task automatic b_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      bus.comp_en_b = 1'b1;
      bus.comp_we_b = 1'b0;
      bus.comp_addr_b = a;
      @(negedge clk);
      d = bus.comp_dout_b;
      bus.comp_en_b = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] d;
      tbl = '{
         '{13'h0010, 32'hA0}, '{13'h0011, 32'hA1}, '{13'h0012, 32'hA2}, '{13'h0013, 32'hA3},
         '{13'h0014, 32'hB4}, '{13'h0015, 32'hB5}, '{13'h0200, 32'hC0}, '{13'h020C, 32'hC4},
         '{13'h1FFE, 32'hD0}, '{13'h1FFF, 32'hD1}, '{13'h0000, 32'hD2}, '{13'h0001, 32'hD3},
         '{13'h0300, 32'hE2}, '{13'h0040, 32'h22}, '{13'h0041, 32'h44}
      };
      bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.stride = '0; bus.len = '0;
      bus.s_axis_valid = 1'b0; bus.s_axis_data = '0; bus.s_axis_last = 1'b0;
      bus.m_axis_ready = 1'b0;
      bus.comp_en_b = 1'b0; bus.comp_we_b = 1'b0; bus.comp_addr_b = '0; bus.comp_din_b = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_flags", {bus.busy, bus.done, bus.err_last, bus.s_axis_ready, bus.m_axis_valid,
                        bus.m_axis_last}, 0);
      chk("rst_data", bus.m_axis_data, 0);
      chk("rst_count", bus.xfer_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      write_xfer(13'h10, 13'd1, 16'd4, 4, 4, 32'hA0, 1'b0);
      write_xfer(13'h14, 13'd1, 16'd2, 2, 2, 32'hB4, 1'b0);
      read_xfer(13'h10, 13'd2, 16'd3, 4'b1001);
      read_xfer(13'h10, 13'd1, 16'd4, 4'b1111);
      write_xfer(13'h200, 13'd3, 16'd8, 5, 5, 32'hC0, 1'b1);
      read_xfer(13'h200, 13'd3, 16'd8, 4'b1111);
      write_xfer(13'h1FFE, 13'd1, 16'd4, 4, 4, 32'hD0, 1'b0);
      write_xfer(13'h300, 13'd0, 16'd3, 3, 0, 32'hE0, 1'b1);
      // port collisions: B write beats A write; B read during A write sees old data
      bus.comp_en_b = 1'b1; bus.comp_we_b = 1'b1; bus.comp_addr_b = 13'h41; bus.comp_din_b = 32'h33;
      @(negedge clk);
      bus.comp_en_b = 1'b0; bus.comp_we_b = 1'b0;
      start_cmd(1'b0, 13'h40, 13'd1, 16'd2);
      bus.s_axis_valid = 1'b1; bus.s_axis_data = 32'h11; bus.s_axis_last = 1'b0;
      bus.comp_en_b = 1'b1; bus.comp_we_b = 1'b1; bus.comp_addr_b = 13'h40; bus.comp_din_b = 32'h22;
      @(negedge clk);
      bus.s_axis_data = 32'h44; bus.s_axis_last = 1'b1;
      bus.comp_we_b = 1'b0; bus.comp_addr_b = 13'h41;
      @(negedge clk);
      chk("rdw_old_data", bus.comp_dout_b, 32'h33);
      chk("col_done", bus.done, 1);
      bus.comp_en_b = 1'b0; bus.s_axis_valid = 1'b0; bus.s_axis_last = 1'b0;
      @(negedge clk);
      // zero length, with a second start while busy that must be ignored
      start_cmd(1'b0, 13'h50, 13'd1, 16'd0);
      chk("len0_busy", bus.busy, 1);
      chk("len0_no_done_yet", bus.done, 0);
      chk("len0_no_ready", bus.s_axis_ready, 0);
      bus.start = 1'b1; bus.dir = 1'b1; bus.base_addr = 13'h10; bus.len = 16'd5;
      @(negedge clk);
      bus.start = 1'b0;
      chk("len0_done_t2", bus.done, 1);
      chk("len0_count", bus.xfer_count, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ignored_start_idle", {bus.busy, bus.done, bus.m_axis_valid, bus.s_axis_ready}, 0);
      end
      // reset in the middle of a read
      start_cmd(1'b1, 13'h10, 13'd1, 16'd4);
      bus.m_axis_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", {bus.busy, bus.done, bus.err_last, bus.s_axis_ready, bus.m_axis_valid,
                            bus.m_axis_last}, 0);
      chk("rst_mid_data", bus.m_axis_data, 0);
      chk("rst_mid_count", bus.xfer_count, 0);
      bus.m_axis_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_no_done", {bus.busy, bus.done, bus.m_axis_valid}, 0);
      end
      read_xfer(13'h10, 13'd1, 16'd4, 4'b1111);
      foreach (tbl[i]) begin
         b_read(tbl[i].addr, d);
         chk($sformatf("portb_rd_%0h", tbl[i].addr), d, tbl[i].data);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
